// File: rtl/jtag_scan_master.sv
// JTAG scan master: generates TCK from CLK, runs the TAP reset sequence and IR/DR scans.
// Define JTAG_PAUSE_DR_EN to route DR scans through Pause-DR and Exit2-DR before Update.
module jtag_scan_master #(
  parameter int MAX_LEN      = 16,
  parameter int CLK_DIV      = 1,
  parameter int PAUSE_CYCLES = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic                         IS_IR,
  input  logic [$clog2(MAX_LEN+1)-1:0] LEN,
  input  logic [MAX_LEN-1:0]           DATA_IN,
  input  logic                         TDO,
  output logic                         TCK,
  output logic                         TMS,
  output logic                         TDI,
  output logic                         TRST,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [MAX_LEN-1:0]           DATA_OUT
);
  localparam int LW       = $clog2(MAX_LEN + 1);
  localparam int IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW       = $clog2(MAX_LEN + PAUSE_CYCLES + 8);
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RST_LAST = 6;

  typedef enum logic [3:0] {
    IDLE, RST_SEQ, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, PAUSE, EXIT2, UPDATE
  } state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      div_cnt;
  logic               tck_q, tick, tck_rise, tck_fall;
  logic [CW-1:0]      cnt_q, cnt_d, last_q, len_last;
  logic               go_q, go_d, accept, done_q, done_d;
  logic               ir_q, tms, tdi;
  logic [MAX_LEN-1:0] din_q, dout_q;
  logic [LW-1:0]      len_clamp;
  logic [IW-1:0]      bit_idx;

  assign tick     = (div_cnt == DW'(CLK_DIV - 1));
  assign tck_rise = tick & ~tck_q;
  assign tck_fall = tick & tck_q;
  assign BUSY     = (state_q != IDLE) | go_q;
  assign accept   = START & ~BUSY;
  assign bit_idx  = cnt_q[IW-1:0];

  always_comb begin
    len_clamp = LEN;
    if (LEN == '0)
      len_clamp = LW'(1);
    else if (LEN > LW'(MAX_LEN))
      len_clamp = LW'(MAX_LEN);
  end

  assign len_last = CW'(len_clamp - LW'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
      tck_q   <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      tck_q   <= ~tck_q;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RST_SEQ;
      cnt_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
    end
  end

  // Scan parameters are frozen at acceptance; DATA_OUT is cleared then filled bit by bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ir_q   <= 1'b0;
      last_q <= '0;
      din_q  <= '0;
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (accept) begin
        ir_q   <= IS_IR;
        last_q <= len_last;
        din_q  <= DATA_IN;
        dout_q <= '0;
      end else if (state_q == SHIFT && tck_rise) begin
        dout_q[bit_idx] <= TDO;
      end
    end
  end

  // States advance only on TCK falling edges, so TMS/TDI change there and nowhere else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_d    = go_q;
    done_d  = 1'b0;
    tms     = 1'b0;
    tdi     = 1'b0;
    case (state_q)
      RST_SEQ: begin
        tms = (cnt_q != CW'(RST_LAST));
        if (tck_fall) begin
          if (cnt_q == CW'(RST_LAST)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      IDLE: begin
        // One full Run-Test/Idle lead-in period separates acceptance from Select-DR.
        if (accept) begin
          go_d  = 1'b1;
          cnt_d = '0;
        end else if (go_q && tck_fall) begin
          if (cnt_q == '0) begin
            cnt_d = CW'(1);
          end else begin
            state_d = SEL_DR;
            cnt_d   = '0;
            go_d    = 1'b0;
          end
        end
      end
      SEL_DR: begin
        tms = 1'b1;
        if (tck_fall) state_d = ir_q ? SEL_IR : CAPTURE;
      end
      SEL_IR: begin
        tms = 1'b1;
        if (tck_fall) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (tck_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        tms = (cnt_q == last_q);
        tdi = din_q[bit_idx];
        if (tck_fall) begin
          if (cnt_q == last_q) begin
            state_d = EXIT1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      EXIT1: begin
`ifdef JTAG_PAUSE_DR_EN
        tms = ir_q;
        if (tck_fall) state_d = ir_q ? UPDATE : PAUSE;
`else
        tms = 1'b1;
        if (tck_fall) state_d = UPDATE;
`endif
      end
`ifdef JTAG_PAUSE_DR_EN
      PAUSE: begin
        tms = (cnt_q == CW'(PAUSE_CYCLES - 1));
        if (tck_fall) begin
          if (cnt_q == CW'(PAUSE_CYCLES - 1)) begin
            state_d = EXIT2;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      EXIT2: begin
        tms = 1'b1;
        if (tck_fall) state_d = UPDATE;
      end
`endif
      UPDATE: begin
        if (tck_fall) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = RST_SEQ;
        cnt_d   = '0;
      end
    endcase
  end

  assign TCK      = tck_q;
  assign TMS      = tms;
  assign TDI      = tdi;
  assign TRST     = ~(state_q == RST_SEQ && cnt_q == '0);
  assign DONE     = done_q;
  assign DATA_OUT = dout_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Self-checking bench for jtag_scan_master: per-period TMS/TDI/TDO recording against a list-based scan model.
// Honours JTAG_PAUSE_DR_EN the same way as the design.
module tb_jtag_scan_master;
  localparam int MAX_LEN      = 16;
  localparam int PAUSE_CYCLES = 4;
  localparam int LW           = $clog2(MAX_LEN + 1);
`ifdef JTAG_PAUSE_DR_EN
  localparam int DR13_PERIODS = 13 + PAUSE_CYCLES + 6;
`else
  localparam int DR13_PERIODS = 13 + 5;
`endif

  logic               clk = 1'b0, rst = 1'b1, start = 1'b0, is_ir = 1'b0, tdo = 1'b0;
  logic [LW-1:0]      len = '0;
  logic [MAX_LEN-1:0] data_in = '0;
  logic               tck, tms, tdi, trst, busy, done;
  logic [MAX_LEN-1:0] data_out;

  int checks = 0, errors = 0, done_cnt = 0;
  bit q_tms[$], q_tdi[$], q_tdo[$];
  bit recording = 0, rec_pending = 0, echo_mode = 0, tck_prev = 0, last_tdi = 0;
  logic               s_ir;
  int                 s_len, obs_periods;
  logic [MAX_LEN-1:0] s_data, exp_dout;
  logic [63:0]        obs_tms, obs_tdi;

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .CLK_DIV(1), .PAUSE_CYCLES(PAUSE_CYCLES)) dut (
    .CLK(clk), .RST(rst), .START(start), .IS_IR(is_ir), .LEN(len), .DATA_IN(data_in),
    .TDO(tdo), .TCK(tck), .TMS(tms), .TDI(tdi), .TRST(trst), .BUSY(busy), .DONE(done),
    .DATA_OUT(data_out)
  );

  always #5 clk = ~clk;

  // TAP side: one sample per TCK period at the rising edge, TDO updated at each falling edge.
  always @(posedge clk) begin
    #1;
    if (tck && !tck_prev) begin
      last_tdi = tdi;
      if (recording) begin
        q_tms.push_back(tms);
        q_tdi.push_back(tdi);
        q_tdo.push_back(tdo);
      end
    end
    if (!tck && tck_prev) begin
      if (rec_pending) begin
        recording   = 1;
        rec_pending = 0;
      end
      tdo = echo_mode ? last_tdi : ($urandom_range(0, 1) == 1);
    end
    if (done) begin
      done_cnt++;
      recording = 0;
    end
    tck_prev = tck;
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput(tag, {tck, tms, tdi, trst, busy, done, data_out},
                {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {MAX_LEN{1'b0}}});
  endtask

  task automatic checkResetSeq(input string tag);
    int good;
    #1;
    checkOutput({tag, "_release"}, {trst, tms, busy}, 3'b011);
    @(posedge clk); #2;
    checkOutput({tag, "_trst_2nd_clk"}, trst, 1'b0);
    good = 0;
    repeat (10) begin
      @(posedge clk); #2;
      if (trst && tms && busy) good++;
    end
    checkOutput({tag, "_tms_high_10clk"}, good, 10);
    good = 0;
    repeat (2) begin
      @(posedge clk); #2;
      if (trst && !tms && busy) good++;
    end
    checkOutput({tag, "_rti_2clk"}, good, 2);
    @(posedge clk); #2;
    checkOutput({tag, "_busy_fall"}, busy, 1'b0);
  endtask

  task automatic applyStimulus(input logic ir, input int l, input logic [MAX_LEN-1:0] d, input bit echo);
    int cyc = 0;
    @(negedge clk);
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) checkOutput("idle_wait_timeout", busy, 1'b0);
    s_ir = ir; s_len = l; s_data = d; echo_mode = echo;
    is_ir = ir; len = LW'(l); data_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    q_tms.delete(); q_tdi.delete(); q_tdo.delete();
    recording = 0;
    rec_pending = 1;
  endtask

  // Expected TAP traffic: lead-in idle, Select-DR, [Select-IR], Capture, shift bits, exit path, Update.
  task automatic finishScan(input string tag);
    int cyc = 0, n, base, k;
    logic [63:0] etms, etdi, edout;
    etms = '0; etdi = '0; edout = '0;
    while (!done && cyc < 1000) begin
      @(posedge clk); #2;
      cyc++;
    end
    checkOutput({tag, "_done"}, done, 1'b1);
    checkOutput({tag, "_busy_low"}, busy, 1'b0);
    n = (s_len == 0) ? 1 : ((s_len > MAX_LEN) ? MAX_LEN : s_len);
    k = 1;
    etms[k] = 1'b1; k++;
    if (s_ir) begin etms[k] = 1'b1; k++; end
    k++;
    base = k;
    for (int i = 0; i < n; i++) begin
      etms[k] = (i == n - 1);
      etdi[k] = s_data[i];
      k++;
    end
`ifdef JTAG_PAUSE_DR_EN
    if (!s_ir) begin
      k++;
      for (int p = 0; p < PAUSE_CYCLES; p++) begin
        etms[k] = (p == PAUSE_CYCLES - 1);
        k++;
      end
      etms[k] = 1'b1; k++;
    end else begin
      etms[k] = 1'b1; k++;
    end
`else
    etms[k] = 1'b1; k++;
`endif
    k++;
    obs_periods = q_tms.size();
    obs_tms = '0; obs_tdi = '0;
    for (int i = 0; i < q_tms.size() && i < 64; i++) begin
      obs_tms[i] = q_tms[i];
      obs_tdi[i] = q_tdi[i];
    end
    for (int i = 0; i < n; i++)
      if (base + i < q_tdo.size()) edout[i] = q_tdo[base + i];
    exp_dout = edout[MAX_LEN-1:0];
    checkOutput({tag, "_periods"}, obs_periods, k);
    checkOutput({tag, "_tms"}, obs_tms, etms);
    checkOutput({tag, "_tdi"}, obs_tdi, etdi);
    checkOutput({tag, "_data_out"}, data_out, exp_dout);
    @(posedge clk); #2;
    checkOutput({tag, "_done_one_clk"}, done, 1'b0);
  endtask

  initial begin
    int toggles, saved, cyc;
    bit quiet, prev;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 checkResetValues("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    checkResetSeq("por");

    toggles = 0; quiet = 1; prev = tck;
    repeat (8) begin
      @(posedge clk); #2;
      if (tck != prev) toggles++;
      if (tms || tdi) quiet = 0;
      prev = tck;
    end
    checkOutput("idle_tck_toggles", toggles, 8);
    checkOutput("idle_tms_tdi_low", quiet, 1'b1);

    applyStimulus(1'b1, 4, 16'h0005, 1'b0);
    finishScan("ir4");
    checkOutput("ir4_periods_const", obs_periods, 10);
    checkOutput("ir4_tms_const", obs_tms, 64'h186);
    checkOutput("ir4_tdi_const", obs_tdi, 64'h50);

    applyStimulus(1'b0, 13, 16'h0003, 1'b1);
    finishScan("dr13_echo");
    checkOutput("dr13_periods_const", obs_periods, DR13_PERIODS);
    checkOutput("dr13_data_out_const", data_out, 16'h0006);

    applyStimulus(1'b1, 0, 16'hFFFF, 1'b0);
    finishScan("len0");
    checkOutput("len0_periods_const", obs_periods, 7);
    checkOutput("len0_upper_zero", data_out >> 1, 64'h0);

    applyStimulus(1'b1, 20, 16'hBEEF, 1'b0);
    finishScan("len20");
    checkOutput("len20_periods_const", obs_periods, 22);

    applyStimulus(1'b0, 8, 16'h00A5, 1'b0);
    repeat (6) @(negedge clk);
    is_ir = 1'b1; len = LW'(3); data_in = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finishScan("busy_start");
    saved = done_cnt;
    repeat (20) @(negedge clk);
    checkOutput("busy_start_no_rescan", busy, 1'b0);
    checkOutput("busy_start_dout_hold", data_out, exp_dout);
    checkOutput("busy_start_no_done", done_cnt, saved);

    for (int r = 0; r < 10; r++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 20)), MAX_LEN'($urandom), 1'b0);
      finishScan($sformatf("rand%0d", r));
    end

    applyStimulus(1'b0, 13, 16'h1ABC, 1'b0);
    saved = done_cnt;
    cyc = 0;
    while (q_tms.size() < 9 && cyc < 500) begin
      @(posedge clk); #2;
      cyc++;
    end
    checkOutput("mid_reached_shift5", q_tms.size() >= 9, 1'b1);
    #1;
    rst = 1'b1;
    recording = 0;
    rec_pending = 0;
    #1 checkResetValues("mid_reset_same_clk");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetSeq("mid");
    checkOutput("mid_no_done", done_cnt, saved);

    applyStimulus(1'b1, 7, 16'h005A, 1'b0);
    finishScan("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum scan length in bits.
REQ-002 SHALL have parameter CLK_DIV, default 1, CLK cycles per TCK half-period (>=1).
REQ-003 SHALL have parameter PAUSE_CYCLES, default 4, TCK periods spent presenting Pause-DR (>=1).
REQ-004 SHALL have port CLK  input  1  system clock; only clock in the block.
REQ-005 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-006 SHALL have port START  input  1  scan request, sampled on CLK.
REQ-007 SHALL have port IS_IR  input  1  1 = IR scan, 0 = DR scan.
REQ-008 SHALL have port LEN  input  $clog2(MAX_LEN+1)  number of bits to shift.
REQ-009 SHALL have port DATA_IN  input  MAX_LEN  shift data, LSB shifted first.
REQ-010 SHALL have port TDO  input  1  serial data returned by the TAP.
REQ-011 SHALL have port TCK  output  1  generated test clock.
REQ-012 SHALL have port TMS  output  1  test mode select.
REQ-013 SHALL have port TDI  output  1  serial data to the TAP.
REQ-014 SHALL have port TRST  output  1  active-low TAP reset.
REQ-015 SHALL have port BUSY  output  1  high while the reset sequence or a scan is in progress.
REQ-016 SHALL have port DONE  output  1  one-CLK pulse at scan completion.
REQ-017 SHALL have port DATA_OUT  output  MAX_LEN  captured TDO bits.

Function
REQ-018 SHALL toggle TCK every CLK_DIV CLK cycles; TMS/TDI change only on the CLK edge where TCK falls; TDO is sampled on the CLK edge where TCK rises.
REQ-019 SHALL, after RST release, drive TRST=0 for 1 TCK period, TMS=1 for 5 periods, then TMS=0 for 1 period (Run-Test/Idle), then drop BUSY.
REQ-020 SHALL accept START only when BUSY=0, latching IS_IR, LEN and DATA_IN and raising BUSY on the next CLK; START while BUSY is ignored.
REQ-021 SHALL clamp LEN=0 to 1 and LEN>MAX_LEN to MAX_LEN.
REQ-022 SHALL use FSM states IDLE, RST_SEQ, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, PAUSE, EXIT2, UPDATE, each presenting TMS for exactly one TCK period (PAUSE for PAUSE_CYCLES periods).
REQ-023 SHALL, for IR scans, drive TMS sequence SEL_DR=1, SEL_IR=1, CAPTURE=0, SHIFT=0 for LEN-1 periods then 1, EXIT1=1, UPDATE=0: total LEN+6 periods.
REQ-024 SHALL, for DR scans, skip SEL_IR: SEL_DR=1, CAPTURE=0, then SHIFT/EXIT1/UPDATE as for IR: total LEN+5 periods.
REQ-025 SHALL drive TDI=DATA_IN[i] during shift period i (i=0..LEN-1) and TDI=0 in all other periods.
REQ-026 SHALL store the TDO sample at the rising TCK of shift period i into DATA_OUT[i]; bits >= LEN read 0.
REQ-027 SHALL pulse DONE for one CLK and drop BUSY on the CLK edge ending the UPDATE period; DATA_OUT holds until the next accepted START.
REQ-028 SHALL hold TMS=0, TDI=0 and keep TCK toggling while IDLE.

Reset
REQ-029 SHALL, while RST=1, force TCK=0, TMS=1, TDI=0, TRST=0, BUSY=1, DONE=0, DATA_OUT=0, state RST_SEQ.
REQ-030 SHALL abort any scan on RST mid-operation, discarding latched data, and rerun the REQ-019 sequence.

Configuration
REQ-031 SHALL, with macro JTAG_PAUSE_DR_EN defined, route DR scans EXIT1 (TMS=0) -> PAUSE (TMS=0 for PAUSE_CYCLES-1 periods, then 1) -> EXIT2 (TMS=1) -> UPDATE: total LEN+PAUSE_CYCLES+6 periods.
REQ-032 SHALL, without JTAG_PAUSE_DR_EN, omit PAUSE/EXIT2 entirely; IR scans never use PAUSE in either build.

Verification
REQ-033 SHALL check reset: release RST -> TRST low 2 CLK, then TMS=1 for 10 CLK, TMS=0 for 2 CLK, BUSY falls (CLK_DIV=1).
REQ-034 SHALL check IR scan: IS_IR=1, LEN=4, DATA_IN=4'h5 -> TMS 1,1,0,0,0,0,1,1,0; TDI 1,0,1,0 in shift periods; DONE after 10 TCK periods.
REQ-035 SHALL check DR scan with TAP model echoing TDI delayed one period: LEN=13, DATA_IN=13'h0003 -> 18 periods without macro, 23 with macro; DATA_OUT=13'h0006.
REQ-036 SHALL check LEN=0 -> 1-bit scan; LEN=20 -> 16-bit scan; START during BUSY -> no effect, DATA_OUT unchanged.
REQ-037 SHALL check RST asserted in SHIFT period 5 -> outputs at reset values same CLK, DONE never pulses, REQ-019 sequence restarts.
